// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU control unit: fetch/decode/execute sequencing, memory wait
// timeout, and sticky status flags.
module cpu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_re,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       acc_we,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       bus_err,
    output logic       illegal,
    output logic [7:0] instr_cnt
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, DECODE, MEM, EXEC, JUMP, HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [4:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] instr_cnt_q, instr_cnt_d;
    logic       halted_q, halted_d;
    logic       bus_err_q, bus_err_d;
    logic       illegal_q, illegal_d;
    logic       in_wait_state;

    assign in_wait_state = (state_q == FETCH) || (state_q == MEM);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_cnt_d  = wait_cnt_q;
        instr_cnt_d = instr_cnt_q;
        halted_d    = halted_q;
        bus_err_d   = bus_err_q;
        illegal_d   = illegal_q;

        case (state_q)
            IDLE: if (start) state_d = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    state_d = LOAD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end
            end
            LOAD: begin
                instr_cnt_d = instr_cnt_q + 8'd1;
                state_d     = DECODE;
            end
            DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_NOP:                         state_d = FETCH;
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: state_d = MEM;
                    OP_JMP:                         state_d = JUMP;
                    OP_JZ:                          state_d = zero ? JUMP : FETCH;
                    OP_HLT:                         state_d = HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    state_d = (op_q == OP_STA) ? FETCH : EXEC;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end
            end
            EXEC:    state_d = FETCH;
            JUMP:    state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        if (state_d == HALT) halted_d = 1'b1;

        // Counter restarts on entering a wait state, counts stalled cycles inside it.
        if (((state_d == FETCH) || (state_d == MEM)) && (state_d != state_q)) begin
            wait_cnt_d = 5'd0;
        end else if (in_wait_state && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 4'h0;
            wait_cnt_q  <= 5'd0;
            instr_cnt_q <= 8'd0;
            halted_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wait_cnt_q  <= wait_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            halted_q    <= halted_d;
            bus_err_q   <= bus_err_d;
            illegal_q   <= illegal_d;
        end
    end

    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        ir_re   = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        acc_we  = 1'b0;
        alu_op  = 2'b00;
        case (state_q)
            FETCH: mem_rd = 1'b1;
            LOAD: begin
                ir_re  = 1'b1;
                pc_inc = 1'b1;
            end
            MEM: begin
                if (op_q == OP_STA) mem_wr = 1'b1;
                else                mem_rd = 1'b1;
            end
            EXEC: begin
                acc_we = 1'b1;
                case (op_q)
                    OP_ADD:  alu_op = 2'b01;
                    OP_SUB:  alu_op = 2'b10;
                    default: alu_op = 2'b00;
                endcase
            end
            JUMP:    pc_load = 1'b1;
            default: ;
        endcase
    end

    assign halted    = halted_q;
    assign bus_err   = bus_err_q;
    assign illegal   = illegal_q;
    assign instr_cnt = instr_cnt_q;

endmodule
